// File: rtl/credit_flit_sender_if.sv
// Flit transmitter bundle: crossbar-side handshake, link-side output and the
// credit return path.
//   valid_i/data_i/ready_o : crossbar flit handshake (accept on valid_i & ready_o)
//   valid_o/data_o         : registered link flit; the link has no back-pressure
//   credit_upd             : one-cycle pulse from the receiver, one credit back
//   credit_cnt             : current credit count
//   err_o                  : sticky protocol error
// modport slave is the transmitter's view, modport master the driver's view.
interface credit_flit_sender_if #(
  parameter int DW = 16
);
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic          ready_o;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          credit_upd;
  logic [7:0]    credit_cnt;
  logic          err_o;

  modport slave (
    input  valid_i, data_i, credit_upd,
    output ready_o, valid_o, data_o, credit_cnt, err_o
  );

  modport master (
    output valid_i, data_i, credit_upd,
    input  ready_o, valid_o, data_o, credit_cnt, err_o
  );
endinterface

// File: rtl/credit_flit_sender.sv
// Credit-based wormhole flit transmitter for one egress port.
// Accepts HEAD/BODY/TAIL flits (type in data_i[DW-1:DW-2]) from the crossbar,
// registers them onto the link, spends one credit per forwarded flit and
// recovers one per credit_upd pulse. Packet framing is checked against
// PKT_LEN; with WHOLE_PKT=1 a HEAD waits until a full packet of credits exists.
// Flit type encoding: 2'b10 HEAD, 2'b01 TAIL, 2'b00 BODY (2'b11 is handled
// as a BODY).
// Ports:
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : credit_flit_sender_if.slave (crossbar handshake, link, credits, error)
module credit_flit_sender #(
  parameter int DW        = 16,
  parameter int CREDITS   = 8,
  parameter int PKT_LEN   = 4,
  parameter bit WHOLE_PKT = 1'b0
) (
  input  logic                   clk,
  input  logic                   rstn,
  credit_flit_sender_if.slave    bus
);

  typedef enum logic [1:0] {
    FT_BODY = 2'b00,
    FT_TAIL = 2'b01,
    FT_HEAD = 2'b10,
    FT_RSVD = 2'b11
  } flit_type_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [7:0] CREDITS_L  = 8'(CREDITS);
  localparam logic [7:0] PKT_LEN_L  = 8'(PKT_LEN);
  localparam logic [7:0] PKT_LAST_L = 8'(PKT_LEN - 1);

  state_e        state_q, state_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          valid_q;
  logic [DW-1:0] data_q;

  flit_type_e ftype;
  logic       is_head, is_tail;
  logic       ready, send, discard, fwd;
  logic       sat_err, frame_err;

  assign ftype   = flit_type_e'(bus.data_i[DW-1 -: 2]);
  assign is_head = (ftype == FT_HEAD);
  assign is_tail = (ftype == FT_TAIL);

  // ready depends only on registered state and the presented flit type, so a
  // credit returned this cycle becomes usable on the next one.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    ready = (cnt_q != 8'd0);
    if (state_q == IDLE) begin
      if (!is_head) begin
        ready = 1'b1;                       // stray BODY/TAIL: discard path
      end else if (WHOLE_PKT) begin
        ready = (cnt_q >= PKT_LEN_L);
      end
    end
  end

  assign send    = bus.valid_i & ready;
  assign discard = send & (state_q == IDLE) & ~is_head;
  assign fwd     = send & ~discard;       // only forwarded flits spend credit

  // Credit counter. A return that would exceed the receiver's buffer size is
  // a protocol violation: the count saturates and the error is flagged.
  always_comb begin
    cnt_d   = cnt_q;
    sat_err = 1'b0;
    unique case ({fwd, bus.credit_upd})
      2'b10:   cnt_d = cnt_q - 8'd1;
      2'b01: begin
        if (cnt_q == CREDITS_L) sat_err = 1'b1;
        else                    cnt_d   = cnt_q + 8'd1;
      end
      default: cnt_d = cnt_q;              // idle, or spend and return cancel
    endcase
  end

  // Packet framing. idx counts flits of the current packet already accepted,
  // so a legal packet sees its TAIL exactly at idx == PKT_LEN-1.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    frame_err = 1'b0;
    if (send) begin
      unique case (state_q)
        IDLE: begin
          if (is_head) begin
            state_d = BUSY;
            idx_d   = 8'd1;
          end else begin
            frame_err = 1'b1;
          end
        end
        BUSY: begin
          if (is_head) begin
            frame_err = 1'b1;              // unterminated packet, restart
            idx_d     = 8'd1;
          end else if (is_tail) begin
            frame_err = (idx_q != PKT_LAST_L);
            state_d   = IDLE;
            idx_d     = 8'd0;
          end else begin
            frame_err = (idx_q >= PKT_LAST_L); // BODY where the TAIL belongs
            idx_d     = idx_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign err_d = err_q | sat_err | frame_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q   <= 8'd0;
      cnt_q   <= CREDITS_L;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      valid_q <= fwd;
      if (send) data_q <= bus.data_i;
    end
  end

  assign bus.ready_o    = ready;
  assign bus.valid_o    = valid_q;
  assign bus.data_o     = data_q;
  assign bus.credit_cnt = cnt_q;
  assign bus.err_o      = err_q;

endmodule
